// File: rtl/fifo_parser_if.sv
// fifo_parser_param_if: handshake/data bundle for fifo_parser_param.
// master drives din/wr_en/rd_en and observes everything else; slave is the FIFO side.
interface fifo_parser_param_if #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             full;
    logic             almost_full;
    logic             prog_full;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             empty;
    logic             almost_empty;
    logic [CW-1:0]    data_count;
    logic             overflow;
    logic             underflow;
    modport master (
        output din, wr_en, rd_en,
        input  full, almost_full, prog_full, dout, valid, empty, almost_empty,
               data_count, overflow, underflow
    );
    modport slave (
        input  din, wr_en, rd_en,
        output full, almost_full, prog_full, dout, valid, empty, almost_empty,
               data_count, overflow, underflow
    );
endinterface

// File: rtl/fifo_parser_param.sv
// fifo_parser_param: synchronous FIFO with registered read data and occupancy flags.
// Ports: clk, rst_n (async assert, active low), bus (fifo_parser_param_if.slave):
//   din/wr_en write side, rd_en/dout/valid read side, full/almost_full/prog_full/
//   empty/almost_empty/data_count status, overflow/underflow sticky errors.
// Macro FIFO_PARSER_ERR_FLAGS_EN enables the sticky error flags; otherwise they read 0.
module fifo_parser_param #(
    parameter int WIDTH            = 33,
    parameter int DEPTH            = 8,
    parameter int PROG_FULL_THRESH = 3
) (
    input logic                clk,
    input logic                rst_n,
    fifo_parser_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q;
    logic             rd_acc, wr_acc;
    // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
    always_comb begin
        rd_acc   = bus.rd_en && (count_q != '0);
        wr_acc   = bus.wr_en && ((count_q != CW'(DEPTH)) || rd_acc);
        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        dout_d   = rd_acc ? mem[rd_ptr_q] : dout_q;
        count_d  = (wr_acc && !rd_acc) ? count_q + 1'b1 :
                   (rd_acc && !wr_acc) ? count_q - 1'b1 : count_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= rd_acc;
        end
    end
    // Storage is not reset; a reset simply rewinds the pointers and count.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) mem[wr_ptr_q] <= bus.din;
    end
`ifdef FIFO_PARSER_ERR_FLAGS_EN
    logic ovf_q, unf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (bus.wr_en && !wr_acc);
            unf_q <= unf_q | (bus.rd_en && !rd_acc);
        end
    end
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif
    assign bus.full         = count_q == CW'(DEPTH);
    assign bus.almost_full  = count_q >= CW'(DEPTH - 1);
    assign bus.prog_full    = count_q >= CW'(PROG_FULL_THRESH);
    assign bus.empty        = count_q == '0;
    assign bus.almost_empty = count_q <= CW'(1);
    assign bus.data_count   = count_q;
    assign bus.dout         = dout_q;
    assign bus.valid        = valid_q;
endmodule

// File: tb/tb_fifo_parser_param.sv
// tb_fifo_parser_param: directed self-checking bench for fifo_parser_param (DEPTH=8, WIDTH=33).
module tb_fifo_parser_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic exp_err;
    logic [32:0] q [$];
    logic [32:0] exp_d;
    logic exp_v, rd_a, wr_a;
    fifo_parser_param_if #(.WIDTH(33), .DEPTH(8)) bus ();
    fifo_parser_param #(.WIDTH(33), .DEPTH(8), .PROG_FULL_THRESH(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
`ifdef FIFO_PARSER_ERR_FLAGS_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        bus.din = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        tick(); tick();
        chk("rst_empty", 64'(bus.empty), 1);
        chk("rst_aempty", 64'(bus.almost_empty), 1);
        chk("rst_full", 64'(bus.full), 0);
        chk("rst_afull", 64'(bus.almost_full), 0);
        chk("rst_pfull", 64'(bus.prog_full), 0);
        chk("rst_count", 64'(bus.data_count), 0);
        chk("rst_valid", 64'(bus.valid), 0);
        chk("rst_dout", 64'(bus.dout), 0);
        chk("rst_ovf", 64'(bus.overflow), 0);
        chk("rst_unf", 64'(bus.underflow), 0);
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 33'h5;
        tick();
        chk("rst_ignore_count", 64'(bus.data_count), 0);
        chk("rst_ignore_unf", 64'(bus.underflow), 0);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        rst_n = 1'b1;
        tick();
        // fill 1..8
        for (int i = 1; i <= 8; i++) begin
            bus.din = 33'(i); bus.wr_en = 1'b1;
            tick();
            chk("fill_count", 64'(bus.data_count), 64'(i));
            chk("fill_afull", 64'(bus.almost_full), 64'(i >= 7));
            chk("fill_pfull", 64'(bus.prog_full), 64'(i >= 3));
            chk("fill_full", 64'(bus.full), 64'(i == 8));
            chk("fill_aempty", 64'(bus.almost_empty), 64'(i <= 1));
        end
        bus.wr_en = 1'b0;
        // drain 1..8
        for (int i = 1; i <= 8; i++) begin
            bus.rd_en = 1'b1;
            tick();
            chk("drain_valid", 64'(bus.valid), 1);
            chk("drain_dout", 64'(bus.dout), 64'(i));
        end
        bus.rd_en = 1'b0;
        tick();
        chk("drain_empty", 64'(bus.empty), 1);
        chk("drain_valid_off", 64'(bus.valid), 0);
        chk("drain_dout_hold", 64'(bus.dout), 8);
        // refill across the pointer wrap
        for (int i = 1; i <= 8; i++) begin
            bus.din = 33'(i); bus.wr_en = 1'b1;
            tick();
        end
        chk("refill_full", 64'(bus.full), 1);
        bus.din = 33'h77;
        tick();
        chk("ovf_count", 64'(bus.data_count), 8);
        chk("ovf_set", 64'(bus.overflow), 64'(exp_err));
        bus.wr_en = 1'b0;
        tick();
        chk("ovf_sticky", 64'(bus.overflow), 64'(exp_err));
        // simultaneous read and write while full
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 33'h9;
        tick();
        chk("fullrw_valid", 64'(bus.valid), 1);
        chk("fullrw_dout", 64'(bus.dout), 1);
        chk("fullrw_count", 64'(bus.data_count), 8);
        chk("fullrw_full", 64'(bus.full), 1);
        bus.wr_en = 1'b0;
        for (int i = 2; i <= 9; i++) begin
            tick();
            chk("fullrw_valid2", 64'(bus.valid), 1);
            chk("fullrw_dout2", 64'(bus.dout), 64'(i));
        end
        bus.rd_en = 1'b0;
        tick();
        chk("fullrw_empty", 64'(bus.empty), 1);
        // simultaneous read and write while empty
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 33'hA;
        tick();
        chk("emptyrw_valid", 64'(bus.valid), 0);
        chk("emptyrw_count", 64'(bus.data_count), 1);
        chk("emptyrw_unf", 64'(bus.underflow), 64'(exp_err));
        bus.wr_en = 1'b0;
        tick();
        chk("emptyrw_rd_valid", 64'(bus.valid), 1);
        chk("emptyrw_rd_dout", 64'(bus.dout), 33'hA);
        chk("emptyrw_rd_empty", 64'(bus.empty), 1);
        tick();
        chk("unf_valid", 64'(bus.valid), 0);
        chk("unf_dout_hold", 64'(bus.dout), 33'hA);
        chk("unf_sticky", 64'(bus.underflow), 64'(exp_err));
        bus.rd_en = 1'b0;
        // streaming traffic checked against a queue model
        for (int i = 0; i < 20; i++) begin
            bus.din = 33'h100 + 33'(i); bus.wr_en = 1'b1; bus.rd_en = (i % 3) != 0;
            rd_a = bus.rd_en && q.size() != 0;
            wr_a = bus.wr_en && (q.size() != 8 || rd_a);
            exp_v = rd_a;
            if (rd_a) exp_d = q.pop_front();
            if (wr_a) q.push_back(bus.din);
            tick();
            chk("stream_valid", 64'(bus.valid), 64'(exp_v));
            if (exp_v) chk("stream_dout", 64'(bus.dout), 64'(exp_d));
            chk("stream_count", 64'(bus.data_count), 64'(q.size()));
        end
        // reset mid-stream with traffic still applied
        rst_n = 1'b0;
        #1;
        chk("midrst_empty", 64'(bus.empty), 1);
        chk("midrst_count", 64'(bus.data_count), 0);
        chk("midrst_valid", 64'(bus.valid), 0);
        chk("midrst_ovf", 64'(bus.overflow), 0);
        chk("midrst_unf", 64'(bus.underflow), 0);
        tick();
        chk("midrst_hold_count", 64'(bus.data_count), 0);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        rst_n = 1'b1;
        tick();
        bus.wr_en = 1'b1; bus.din = 33'h1_5555_AAAA;
        tick();
        bus.din = 33'h66;
        tick();
        chk("post_count", 64'(bus.data_count), 2);
        bus.wr_en = 1'b0; bus.rd_en = 1'b1;
        tick();
        chk("post_dout0", 64'(bus.dout), 33'h1_5555_AAAA);
        tick();
        chk("post_dout1", 64'(bus.dout), 33'h66);
        chk("post_valid", 64'(bus.valid), 1);
        bus.rd_en = 1'b0;
        tick();
        chk("post_empty", 64'(bus.empty), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_parser_param.md
FIFO_PARSER_PARAM -- requirements
Module: fifo_parser_param

Interface
REQ-001 Parameter WIDTH, default 33: data word width in bits, 1 to 512.
REQ-002 Parameter DEPTH, default 8: storage entries; power of two, 2 to 1024.
REQ-003 Parameter PROG_FULL_THRESH, default 3: prog_full asserts when occupancy >= this value; range 1 to DEPTH.
REQ-004 Localparam CW = log2(DEPTH)+1: count width.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset; assertion takes effect immediately, release is synchronous to clk.
REQ-007 din  in  WIDTH  write data.
REQ-008 wr_en  in  1  write request.
REQ-009 full  out  1  occupancy == DEPTH.
REQ-010 almost_full  out  1  occupancy >= DEPTH-1.
REQ-011 prog_full  out  1  occupancy >= PROG_FULL_THRESH.
REQ-012 rd_en  in  1  read request.
REQ-013 dout  out  WIDTH  read data, registered.
REQ-014 valid  out  1  dout holds data returned by the previous cycle's accepted read.
REQ-015 empty  out  1  occupancy == 0.
REQ-016 almost_empty  out  1  occupancy <= 1.
REQ-017 data_count  out  CW  current occupancy, 0 to DEPTH.
REQ-018 overflow  out  1  sticky error flag (see Configuration).
REQ-019 underflow  out  1  sticky error flag (see Configuration).

Function
REQ-020 Read accepted = rd_en && !empty; write accepted = wr_en && (!full || read accepted).
REQ-021 Accepted write: din stored at write pointer; pointer advances modulo DEPTH (wraps DEPTH-1 -> 0).
REQ-022 Accepted read: entry at read pointer loaded into dout on the same edge; pointer advances modulo DEPTH; valid = 1 on the following cycle only.
REQ-023 Read latency: one cycle from accepted rd_en to valid/dout.
REQ-024 No accepted read: valid = 0 and dout holds its last value.
REQ-025 Occupancy: +1 for write only, -1 for read only, unchanged for both or neither; never exceeds DEPTH, never goes below 0.
REQ-026 Full with rd_en and wr_en both high: both accepted, occupancy stays DEPTH, full stays 1.
REQ-027 Empty with rd_en and wr_en both high: write accepted, read rejected, occupancy becomes 1, valid = 0 next cycle.
REQ-028 Rejected write (full, no read): storage, pointers and count are unchanged.
REQ-029 Rejected read (empty): storage, pointers and count are unchanged.
REQ-030 full, almost_full, prog_full, empty, almost_empty and data_count are derived from the registered occupancy and reflect it in the cycle after the causing edge.
REQ-031 Data is delivered in strict write order across any number of pointer wraps.

Reset
REQ-032 rst_n low: pointers = 0, occupancy = 0, dout = 0, valid = 0, overflow = 0, underflow = 0.
REQ-033 Outputs while in reset: empty = 1, almost_empty = 1, full = 0, almost_full = 0, prog_full = 0, data_count = 0.
REQ-034 Reset asserted mid-transfer discards all stored entries; storage contents need not be cleared.
REQ-035 wr_en and rd_en are ignored while rst_n is low and on the first edge at which rst_n is sampled low.

Configuration
REQ-036 Macro FIFO_PARSER_ERR_FLAGS_EN defined: overflow sets on any rejected write; underflow sets on any rejected read; both stay 1 until reset.
REQ-037 Macro FIFO_PARSER_ERR_FLAGS_EN undefined: overflow and underflow are tied to 0 and no flag registers exist.

Verification
REQ-038 DEPTH=8: write 0x1..0x8 on consecutive cycles -> full = 1, data_count = 8, almost_full rises at count 7, prog_full rises at count 3.
REQ-039 Full FIFO, rd_en = 1 for 8 cycles -> valid pulses with dout 0x1..0x8 one cycle after each read, then empty = 1.
REQ-040 Full FIFO, rd_en = 1 and wr_en = 1 with din = 0x9 -> dout = 0x1, count stays 8; 8 further reads return 0x2..0x9.
REQ-041 Empty FIFO, rd_en = 1 and wr_en = 1 with din = 0xA -> valid = 0, count = 1; next read returns 0xA.
REQ-042 Macro defined: write to full FIFO -> overflow = 1 and stays 1; read from empty FIFO -> underflow = 1; rst_n low -> both 0.
REQ-043 20 random writes and reads (wrapping 2.5 times), then rst_n pulsed low mid-stream -> empty = 1, count = 0 immediately; subsequent data is correct.
